dot_product_feeder: RTL and testbench
=====================================

Name: dot_product_feeder

Overview:
Front-end loader for the 8-lane dot-product unit. It accepts element pairs (a_i, b_i) one per cycle over a valid/ready stream and assembles them into the parallel vector_a/vector_b operands. It then holds the operands stable for the unit's pipeline latency, captures the unit's result, and returns it over a valid/ready result stream with the element count.

Parameters:
N, 8, vector length (lanes of the dot-product unit)
W, 8, element width in bits
RW, 19, result width (2*W + clog2(N))
LAT, 2, dot-product unit latency in clock edges from stable operands to valid result

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  element pair valid
in_ready  output  1  feeder can accept an element pair
in_a  input  W  element of vector A
in_b  input  W  element of vector B
in_last  input  1  final element of the current vector; qualified by in_valid
vec_a  output  W x N (unpacked [N-1:0])  operand A to the dot-product unit
vec_b  output  W x N (unpacked [N-1:0])  operand B to the dot-product unit
dp_result  input  RW  result from the dot-product unit
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
res_data  output  RW  captured dot product
res_count  output  clog2(N)+1  number of elements accepted for this vector (1..N)

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = FILL; idx = 0; wait_cnt = 0.
  - All vec_a/vec_b lanes = 0.
  - res_valid = 0, res_data = 0, res_count = 0.
  - in_ready = 0 while reset is high.
- in_ready = (state == FILL) && !reset. This is the only combinational output.
- Handshake:
  - An input beat transfers on an edge where in_valid && in_ready.
  - A result transfers on an edge where res_valid && res_ready.
  - in_a, in_b and in_last are ignored when there is no transfer.
- State FILL:
  - On each input transfer: vec_a[idx] <= in_a, vec_b[idx] <= in_b, idx <= idx + 1.
  - The vector closes on the transfer where in_last == 1 or idx == N-1, whichever comes first.
  - On close: res_count <= idx + 1, idx <= 0, wait_cnt <= 0, go to WAIT.
  - in_last on the Nth element closes normally. No more than N elements are ever accepted per vector.
  - Lanes not written (short vector) keep their value of 0, so they contribute nothing to the sum.
- State WAIT:
  - in_ready = 0; vec_a/vec_b held constant.
  - wait_cnt increments each cycle.
  - On the edge where wait_cnt == LAT: res_data <= dp_result, res_valid <= 1, go to DONE.
  - Result: if the closing element is accepted at edge k, res_valid is high after edge k+LAT+1 (k+3 by default).
- State DONE:
  - res_valid = 1; res_data and res_count held stable until the result transfer.
  - in_ready = 0; vec_a/vec_b still held.
  - On the result transfer: res_valid <= 0, all vec_a/vec_b lanes <= 0, go to FILL.
  - in_ready is high in the cycle after the result transfer.
- Throughput:
  - One vector per (n + LAT + 2) cycles minimum, where n = elements in the vector, with res_ready tied high.
  - There is no overlap between filling the next vector and draining the current result.
- Widths: the feeder performs no arithmetic on data. res_data is a direct register copy of dp_result (RW bits, unsigned). idx and res_count are clog2(N)+1 bits wide.
- Reset mid-operation: reset in any state aborts the vector, discards any pending result and applies the reset values above. The dot-product unit shares the same reset; stale dp_result values are never captured because wait_cnt restarts from 0 only after a new vector closes.
- in_valid held high while in_ready = 0: no effect, no element lost. The producer must hold its data until the transfer.
- res_ready high while res_valid = 0: no effect.

Test Plan:
- Full vector: a = 1..8, b = 1..8, in_last on element 8, res_ready = 1 -> res_valid 3 cycles after the final transfer; res_data = 204, res_count = 8, in_ready high the cycle after the result transfer.
- Max values: all a = b = 255 -> res_data = 520200 (no overflow in 19 bits), res_count = 8.
- Short vector: a = (2,3,4), b = (5,6,7), in_last on element 3 -> res_data = 56, res_count = 3; lanes 3..7 observed as 0 on vec_a/vec_b.
- Missing in_last: 8 elements with in_last = 0, then a 9th beat offered -> vector closes after the 8th; in_ready = 0 for the 9th beat until the result is drained; the 9th beat becomes element 0 of the next vector.
- Backpressure: res_ready low for 5 cycles after res_valid rises -> res_valid, res_data and res_count stable; in_ready = 0 throughout; the vector is cleared only after res_ready goes high.
- Reset in WAIT (one cycle after close) -> next cycle state FILL, res_valid = 0, all lanes 0; a subsequent vector a = 1..8, b = 1..8 returns 204 with no stale result.

Source files
------------

// File: rtl/dot_product_feeder.sv
// rtl/dot_product_feeder.sv - element-pair loader and result capture for the 8-lane dot-product unit
module dot_product_feeder #(
  parameter int N   = 8,
  parameter int W   = 8,
  parameter int RW  = 19,
  parameter int LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_a,
  input  logic [W-1:0]          in_b,
  input  logic                  in_last,
  output logic [W-1:0]          vec_a [N-1:0],
  output logic [W-1:0]          vec_b [N-1:0],
  input  logic [RW-1:0]         dp_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [RW-1:0]         res_data,
  output logic [$clog2(N):0]    res_count
);

  localparam int IW = $clog2(N) + 1;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(LAT + 2);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [CW-1:0] LAT_CNT  = CW'(LAT);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_wait_cnt;
  logic [W-1:0]      r_vec_a [N-1:0];
  logic [W-1:0]      r_vec_b [N-1:0];
  logic              r_res_valid;
  logic [RW-1:0]     r_res_data;
  logic [IW-1:0]     r_res_count;

  logic              w_in_fire;
  logic              w_close;
  logic              w_capture;
  logic              w_drain;
  logic [LW-1:0]     w_lane;

  assign w_lane    = r_idx[LW-1:0];
  assign vec_a     = r_vec_a;
  assign vec_b     = r_vec_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_count = r_res_count;

  // State register; reset always returns to filling an empty vector
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next;
  end

  // Next state and handshake decode; the vector closes on in_last or the Nth lane
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    w_in_fire = 1'b0;
    w_close   = 1'b0;
    w_capture = 1'b0;
    w_drain   = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready  = !reset;
        w_in_fire = in_valid && !reset;
        if (w_in_fire && (in_last || (r_idx == LAST_IDX))) begin
          w_close = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == LAT_CNT) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_drain = 1'b1;
          w_next  = S_FILL;
        end
      end
      default: w_next = S_FILL;
    endcase
  end

  // Operand lanes, element index, latency counter and captured result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_count <= '0;
      for (int i = 0; i < N; i++) begin
        r_vec_a[i] <= '0;
        r_vec_b[i] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_vec_a[w_lane] <= in_a;
        r_vec_b[w_lane] <= in_b;
        if (w_close) begin
          r_res_count <= r_idx + ONE_IDX;
          r_idx       <= '0;
          r_wait_cnt  <= '0;
        end else begin
          r_idx <= r_idx + ONE_IDX;
        end
      end
      if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + ONE_CNT;
      end
      if (w_capture) begin
        r_res_data  <= dp_result;
        r_res_valid <= 1'b1;
      end
      // Clearing lanes on drain keeps unwritten lanes of a short vector at zero
      if (w_drain) begin
        r_res_valid <= 1'b0;
        for (int i = 0; i < N; i++) begin
          r_vec_a[i] <= '0;
          r_vec_b[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// tb/tb_dot_product_feeder.sv - self-checking bench for dot_product_feeder
module tb_dot_product_feeder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic [7:0]  vec_a [7:0];
  logic [7:0]  vec_b [7:0];
  logic [18:0] dp_result;
  logic        res_valid;
  logic        res_ready;
  logic [18:0] res_data;
  logic [3:0]  res_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] va [8];
  logic [7:0] vb [8];

  dot_product_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .dp_result (dp_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dot-product unit stand-in: two pipeline stages over the presented operands
  logic [18:0] dp_s1, dp_s2;
  function automatic logic [18:0] lanes_dot();
    logic [18:0] s = '0;
    for (int i = 0; i < 8; i++) s = s + 19'(vec_a[i]) * 19'(vec_b[i]);
    return s;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_s1 <= '0;
      dp_s2 <= '0;
    end else begin
      dp_s1 <= lanes_dot();
      dp_s2 <= dp_s1;
    end
  end
  assign dp_result = dp_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_dot(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(va[i]) * int'(vb[i]);
    return s;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("send_timeout", 32'(t < 50), 1);
    step();
    idle_inputs();
  endtask

  task automatic wait_res(input string tag, input int exp_data, input int exp_cnt);
    int cyc = 0;
    while (!res_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_count"}, res_count, exp_cnt);
  endtask

  task automatic check_lanes(input string tag, input int n);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_lane_a"}, vec_a[i], (i < n) ? va[i] : 8'd0);
      check({tag, "_lane_b"}, vec_b[i], (i < n) ? vb[i] : 8'd0);
    end
  endtask

  task automatic hold_and_drain(input string tag, input int bp, input int exp_data, input int exp_cnt);
    res_ready = 1'b0;
    for (int c = 0; c < bp; c++) begin
      step();
      check({tag, "_bp_valid"}, res_valid, 1);
      check({tag, "_bp_data"}, res_data, exp_data);
      check({tag, "_bp_count"}, res_count, exp_cnt);
      check({tag, "_bp_in_ready"}, in_ready, 0);
    end
    check({tag, "_pre_drain_in_ready"}, in_ready, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_drain_valid"}, res_valid, 0);
    check({tag, "_drain_in_ready"}, in_ready, 1);
    check_lanes({tag, "_cleared"}, 0);
  endtask

  task automatic run_vec(input string tag, input int n, input logic use_last, input int bp, input logic gaps);
    int exp_data;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) step();
      send(va[i], vb[i], use_last && (i == n - 1));
    end
    exp_data = ref_dot(n);
    wait_res(tag, exp_data, n);
    check_lanes({tag, "_held"}, n);
    hold_and_drain(tag, bp, exp_data, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [7:0] a9, b9;
    reset     = 1'b1;
    res_ready = 1'b0;
    idle_inputs();
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_count", res_count, 0);
    for (int i = 0; i < 8; i++) begin va[i] = 0; vb[i] = 0; end
    check_lanes("rst", 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Full vector 1..8 . 1..8 = 204
    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
    check("full_ref", ref_dot(8), 204);
    run_vec("full", 8, 1'b1, 0, 1'b0);

    // Maximum element values
    for (int i = 0; i < 8; i++) begin va[i] = 8'd255; vb[i] = 8'd255; end
    run_vec("max", 8, 1'b1, 0, 1'b0);

    // Short vector of three elements
    va[0] = 2; va[1] = 3; va[2] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7;
    run_vec("short", 3, 1'b1, 0, 1'b0);

    // Backpressure on the result stream
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
    run_vec("bp", 6, 1'b1, 5, 1'b0);

    // Missing in_last: ninth beat waits, then becomes element 0 of the next vector
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
    for (int i = 0; i < 8; i++) send(va[i], vb[i], 1'b0);
    a9 = 8'($urandom_range(1, 255));
    b9 = 8'($urandom_range(1, 255));
    in_valid = 1'b1; in_a = a9; in_b = b9; in_last = 1'b1;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      check("miss_hold_in_ready", in_ready, 0);
      step();
      cyc++;
    end
    check("miss_latency", cyc, 3);
    check("miss_data", res_data, ref_dot(8));
    check("miss_count", res_count, 8);
    check("miss_ninth_not_taken", in_ready, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("miss_drain_valid", res_valid, 0);
    check("miss_drain_in_ready", in_ready, 1);
    check("miss_lane0_cleared", vec_a[0], 0);
    step();
    idle_inputs();
    check("miss_ninth_lane_a", vec_a[0], a9);
    check("miss_ninth_lane_b", vec_b[0], b9);
    va[0] = a9; vb[0] = b9;
    wait_res("miss_next", ref_dot(1), 1);
    hold_and_drain("miss_next", 0, ref_dot(1), 1);

    // Reset one cycle after close, then a clean full vector
    for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
    for (int i = 0; i < 8; i++) send(va[i], vb[i], i == 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("wrst_res_valid", res_valid, 0);
    check("wrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin va[i] = 0; vb[i] = 0; end
    check_lanes("wrst", 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("wrst_no_stale", res_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'(i + 1); end
    run_vec("after_rst", 8, 1'b1, 0, 1'b0);

    // Randomized vectors against the arithmetic reference
    for (int v = 0; v < 20; v++) begin
      int n;
      logic use_last;
      n = $urandom_range(1, 8);
      use_last = (n < 8) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < 8; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      run_vec("rand", n, use_last, $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
